// File: rtl/fpga_wb_led_regs_pkg.sv
// rtl/fpga_wb_led_regs_pkg.sv - register map, bit indices and helpers for fpga_wb_led_regs
package fpga_wb_led_regs_pkg;

    localparam int ADR_ID         = 'h00;
    localparam int ADR_REV        = 'h01;
    localparam int ADR_SCRATCH    = 'h02;
    localparam int ADR_LED_CTRL   = 'h03;
    localparam int ADR_PERIOD     = 'h04;
    localparam int ADR_INT_STATUS = 'h05;
    localparam int ADR_INT_EN     = 'h06;

    localparam int LED_R_BIT     = 0;
    localparam int LED_G_BIT     = 1;
    localparam int LED_B_BIT     = 2;
    localparam int LED_BLINK_BIT = 3;

    localparam int INT_WRAP_BIT = 0;

    localparam logic [31:0] DEF_REG_DEFAULT = 32'hFAB_DEF_AC;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wr,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = wr[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fpga_led_blink_timer.sv
// rtl/fpga_led_blink_timer.sv - programmable blink timer producing a phase and a wrap pulse
//
// Ports:
//   clk, rst_n  fabric clock, asynchronous active-low reset
//   period      terminal count; 0 stops the timer
//   period_wr   any write to PERIOD; restarts counter and phase
//   phase       blink phase, toggles on each wrap
//   wrap_pulse  single-cycle, high in the cycle whose closing edge wraps the counter
module fpga_led_blink_timer #(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    period_wr,
    output logic                    phase,
    output logic                    wrap_pulse
);

    logic [PERIOD_WIDTH-1:0] counter;

    // A PERIOD write restarts the timer, so it also masks a coincident wrap.
    assign wrap_pulse = (period != '0) && (counter == period) && !period_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (period_wr || (period == '0)) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (wrap_pulse) begin
            counter <= '0;
            phase   <= ~phase;
        end else begin
            counter <= counter + PERIOD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fpga_wb_led_regs.sv
// rtl/fpga_wb_led_regs.sv - Wishbone register responder with RGB LED blink controller
//
// Ports:
//   WB_CLK, WB_RST_n      fabric clock, asynchronous active-low reset
//   WBs_ADR/CYC/STB/WE    Wishbone word address and cycle controls
//   WBs_RD                read indication (WE=0 already implies a read)
//   WBs_BYTE_STB          byte-lane enables for writes
//   WBs_WR_DAT            write data
//   WBs_RD_DAT, WBs_ACK   registered read data and single-cycle acknowledge
//   led_r_o/g_o/b_o       registered LED drives, active-high
//   Interrupt_o           registered level interrupt (blink wrap & enable)
module fpga_wb_led_regs
    import fpga_wb_led_regs_pkg::*;
#(
    parameter int          ADDRWIDTH     = 7,
    parameter int          DATAWIDTH     = 32,
    parameter logic [31:0] ID_VALUE      = 32'hA5BD_0001,
    parameter logic [31:0] REV_VALUE     = 32'h0000_0100,
    parameter logic [31:0] DEF_REG_VALUE = DEF_REG_DEFAULT,
    parameter int          PERIOD_WIDTH  = 24
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST_n,
    input  logic [ADDRWIDTH-1:0] WBs_ADR,
    input  logic                 WBs_CYC,
    input  logic                 WBs_STB,
    input  logic                 WBs_WE,
    input  logic                 WBs_RD,
    input  logic [3:0]           WBs_BYTE_STB,
    input  logic [DATAWIDTH-1:0] WBs_WR_DAT,
    output logic [DATAWIDTH-1:0] WBs_RD_DAT,
    output logic                 WBs_ACK,
    output logic                 led_r_o,
    output logic                 led_g_o,
    output logic                 led_b_o,
    output logic                 Interrupt_o
);

    logic        unused_rd;
    logic        acc, wr_acc, rd_acc;
    logic        wr_scratch, wr_led_ctrl, wr_period, wr_int_status, wr_int_en;
    logic [31:0] scratch;
    logic [3:0]  led_ctrl;
    logic [PERIOD_WIDTH-1:0] period;
    logic        int_status, int_en, int_clr;
    logic        phase, wrap_pulse;
    logic [DATAWIDTH-1:0] rd_val;

    assign unused_rd = WBs_RD;

    // Holding off qualification while ACK is high guarantees no back-to-back ACKs.
    assign acc    = WBs_CYC & WBs_STB & ~WBs_ACK;
    assign wr_acc = acc & WBs_WE;
    assign rd_acc = acc & ~WBs_WE;

    assign wr_scratch    = wr_acc && (WBs_ADR == ADDRWIDTH'(ADR_SCRATCH));
    assign wr_led_ctrl   = wr_acc && (WBs_ADR == ADDRWIDTH'(ADR_LED_CTRL));
    assign wr_period     = wr_acc && (WBs_ADR == ADDRWIDTH'(ADR_PERIOD));
    assign wr_int_status = wr_acc && (WBs_ADR == ADDRWIDTH'(ADR_INT_STATUS));
    assign wr_int_en     = wr_acc && (WBs_ADR == ADDRWIDTH'(ADR_INT_EN));

    assign int_clr = wr_int_status & WBs_BYTE_STB[0] & WBs_WR_DAT[INT_WRAP_BIT];

    fpga_led_blink_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_timer (
        .clk       (WB_CLK),
        .rst_n     (WB_RST_n),
        .period    (period),
        .period_wr (wr_period),
        .phase     (phase),
        .wrap_pulse(wrap_pulse)
    );

    always_comb begin
        rd_val = DEF_REG_VALUE;
        case (WBs_ADR)
            ADDRWIDTH'(ADR_ID):         rd_val = ID_VALUE;
            ADDRWIDTH'(ADR_REV):        rd_val = REV_VALUE;
            ADDRWIDTH'(ADR_SCRATCH):    rd_val = scratch;
            ADDRWIDTH'(ADR_LED_CTRL):   rd_val = DATAWIDTH'(led_ctrl);
            ADDRWIDTH'(ADR_PERIOD):     rd_val = DATAWIDTH'(period);
            ADDRWIDTH'(ADR_INT_STATUS): rd_val = DATAWIDTH'(int_status);
            ADDRWIDTH'(ADR_INT_EN):     rd_val = DATAWIDTH'(int_en);
            default:                    rd_val = DEF_REG_VALUE;
        endcase
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            WBs_ACK    <= 1'b0;
            WBs_RD_DAT <= '0;
            scratch    <= '0;
            led_ctrl   <= '0;
            period     <= '0;
            int_status <= 1'b0;
            int_en     <= 1'b0;
        end else begin
            WBs_ACK <= acc;
            if (rd_acc) begin
                WBs_RD_DAT <= rd_val;
            end
            if (wr_scratch) begin
                scratch <= byte_merge(scratch, WBs_WR_DAT, WBs_BYTE_STB);
            end
            if (wr_led_ctrl && WBs_BYTE_STB[0]) begin
                led_ctrl <= WBs_WR_DAT[3:0];
            end
            if (wr_period) begin
                for (int i = 0; i < PERIOD_WIDTH; i++) begin
                    if (WBs_BYTE_STB[i/8]) begin
                        period[i] <= WBs_WR_DAT[i];
                    end
                end
            end
            if (wr_int_en && WBs_BYTE_STB[0]) begin
                int_en <= WBs_WR_DAT[0];
            end
            // Set has priority over a coincident write-1-to-clear.
            int_status <= (int_status & ~int_clr) | wrap_pulse;
        end
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            led_r_o     <= 1'b0;
            led_g_o     <= 1'b0;
            led_b_o     <= 1'b0;
            Interrupt_o <= 1'b0;
        end else begin
            led_r_o     <= led_ctrl[LED_R_BIT] & (led_ctrl[LED_BLINK_BIT] ? phase : 1'b1);
            led_g_o     <= led_ctrl[LED_G_BIT] & (led_ctrl[LED_BLINK_BIT] ? phase : 1'b1);
            led_b_o     <= led_ctrl[LED_B_BIT] & (led_ctrl[LED_BLINK_BIT] ? phase : 1'b1);
            Interrupt_o <= int_status & int_en;
        end
    end

endmodule

// File: doc/fpga_wb_led_regs.md
# fpga_wb_led_regs

Wishbone responder in the FPGA fabric, driven by the AHB-to-FPGA bridge in the cell macro. Decodes word addresses from the bridge and acknowledges every cycle with a single-cycle ACK. Provides ID, revision and scratch registers, plus an RGB LED controller with a programmable blink timer. A maskable blink-wrap interrupt feeds FB_msg_out[0].

## Interface
- ADDRWIDTH, 7, word-address width (from WBs_ADR[8:2])
- DATAWIDTH, 32, data bus width
- ID_VALUE, 32'hA5BD_0001, value of ID register
- REV_VALUE, 32'h0000_0100, value of REV register
- DEF_REG_VALUE, 32'hFAB_DEF_AC, read value for undecoded addresses
- PERIOD_WIDTH, 24, blink period counter width
- WB_CLK  in  1  fabric clock; all logic on rising edge
- WB_RST_n  in  1  asynchronous, active-low reset
- WBs_ADR  in  ADDRWIDTH  word address
- WBs_CYC  in  1  cycle select
- WBs_STB  in  1  transfer strobe
- WBs_WE  in  1  write enable
- WBs_RD  in  1  read enable (informational; WE=0 means read)
- WBs_BYTE_STB  in  4  byte enables
- WBs_WR_DAT  in  32  write data
- WBs_RD_DAT  out  32  read data, registered
- WBs_ACK  out  1  transfer acknowledge, registered
- led_r_o / led_g_o / led_b_o  out  1 each  LED drives, registered, active-high
- Interrupt_o  out  1  level interrupt, registered

## Operation
- Register map (word address):
  - 0x00 ID (RO) = ID_VALUE
  - 0x01 REV (RO) = REV_VALUE
  - 0x02 SCRATCH (RW, 32 bits)
  - 0x03 LED_CTRL (RW): [0] r_en, [1] g_en, [2] b_en, [3] blink_en
  - 0x04 PERIOD (RW, [PERIOD_WIDTH-1:0])
  - 0x05 INT_STATUS: [0] wrap; write-1-to-clear
  - 0x06 INT_EN (RW): [0]
- Undecoded addresses:
  - Reads return DEF_REG_VALUE.
  - Writes are ignored but still acknowledged.
- Byte strobes gate each byte lane of every RW/W1C register.
  - RO registers ignore writes.
  - Unused bits read 0.
- Blink timer:
  - Counter increments each cycle while PERIOD != 0.
  - When counter == PERIOD: counter wraps to 0, phase toggles, INT_STATUS[0] is set.
  - PERIOD == 0: counter and phase held at 0; no interrupts.
  - Any write to PERIOD (any byte strobe) clears the counter and the phase.
- LED output: led_x = x_en & (blink_en ? phase : 1).
- Interrupt_o = INT_STATUS[0] & INT_EN[0].
- Simultaneous W1C and wrap in the same cycle: set wins, so the bit stays 1.
- Reset values: every register, counter, phase, WBs_RD_DAT, WBs_ACK, all LEDs and Interrupt_o are 0.

## Timing
- Access qualifies in cycle N when CYC & STB & ~WBs_ACK.
- Write: the register is updated at the end of cycle N.
- Read: WBs_RD_DAT is loaded at the end of cycle N from the pre-write register state.
- WBs_ACK is high for exactly cycle N+1. Fixed latency of 1; never two consecutive ACK cycles.
- WBs_RD_DAT holds its value until the next read ACK.
- STB deasserted before qualification: no ACK, no side effects.
- LED and Interrupt_o outputs lag their source state by 1 cycle.
  - Wrap at the end of cycle N: phase and INT_STATUS update at that edge; led_*_o and Interrupt_o change at the end of cycle N+1.
- Reset asserted mid-cycle: ACK drops immediately (async) and no write takes effect.
  - The bridge retries the transfer after reset.

## Structure
- Package fpga_wb_led_regs_pkg holds:
  - register word-address constants
  - LED_CTRL bit indices
  - the INT bit index
  - DEF_REG_VALUE default
- Sub-module fpga_led_blink_timer:
  - inputs: period, period_wr, clock, reset
  - outputs: phase, wrap_pulse
- Top level holds the bus decode, the registers and the output flops.

## Test plan
- Reset, then read 0x00, 0x01, 0x7F -> 32'hA5BD_0001, 32'h0000_0100, 32'hFAB_DEF_AC; each ACK is one cycle, one cycle after STB.
- Write 0x02 = 32'h1234_5678, then write 32'hFFFF_FFFF with BYTE_STB = 4'b0100, then read -> 32'h12FF_5678.
- LED_CTRL = 4'b1011, PERIOD = 3 -> led_r_o and led_g_o toggle every 4 cycles in phase; led_b_o stays 0; INT_STATUS[0] = 1 after the first wrap.
- INT_EN = 1 with a wrap pending -> Interrupt_o = 1; write INT_STATUS = 1 in the exact wrap cycle -> bit stays 1; write 1 between wraps -> Interrupt_o = 0 two cycles later.
- Write PERIOD = 0 while blinking -> phase = 0, no further wraps, LEDs with blink_en set read 0.
- Assert WB_RST_n low mid-blink and mid-ACK -> all outputs 0 immediately; after release, SCRATCH reads 0.
